// File: rtl/reg_xfer_seq.sv
// Register-pair sequencer: EX DE,HL and the LDI/LDD pointer/counter/flag update.
// It drives the register-file select, write and flag ports while busy.
package reg_xfer_pkg;
    localparam int REG_SEL_W = 4;
    typedef logic [REG_SEL_W-1:0] reg_select;

    localparam reg_select REG_B  = 4'd0;
    localparam reg_select REG_C  = 4'd1;
    localparam reg_select REG_D  = 4'd2;
    localparam reg_select REG_E  = 4'd3;
    localparam reg_select REG_H  = 4'd4;
    localparam reg_select REG_L  = 4'd5;
    localparam reg_select REG_A  = 4'd6;
    localparam reg_select REG_F  = 4'd7;
    localparam reg_select REG_BC = 4'd8;
    localparam reg_select REG_DE = 4'd9;
    localparam reg_select REG_HL = 4'd10;
    localparam reg_select REG_SP = 4'd11;

    localparam logic [1:0] OP_EX  = 2'd0;
    localparam logic [1:0] OP_LDI = 2'd1;
    localparam logic [1:0] OP_LDD = 2'd2;
    localparam logic [1:0] OP_NOP = 2'd3;
endpackage

module reg_xfer_seq
    import reg_xfer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    output logic                 busy,
    output logic                 done,
    output logic                 bc_zero,
    output logic [REG_SEL_W-1:0] rf_src1,
    output logic [REG_SEL_W-1:0] rf_src2,
    input  logic [15:0]          rf_out1,
    input  logic [15:0]          rf_out2,
    output logic [REG_SEL_W-1:0] rf_dest,
    output logic [15:0]          rf_in,
    output logic                 rf_write_en,
    output logic [7:0]           rf_f_in,
    output logic                 rf_f_wr,
    input  logic [7:0]           rf_reg_f
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_RD_BC = 3'd2,
        S_WR_A  = 3'd3,
        S_WR_B  = 3'd4,
        S_WR_C  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  op_r;
    logic [15:0] de_r;
    logic [15:0] hl_r;
    logic [15:0] bc_r;
    logic        bc_zero_r;
    logic [15:0] bc_dec_s;
    logic        pv_s;

    // Pointer step for block transfers: LDD walks down, LDI walks up.
    function automatic logic [15:0] ptr_step(input logic [15:0] v, input logic [1:0] o);
        logic [15:0] r;
        if (o == OP_LDD) begin
            r = v - 16'd1;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // Flag image after a block transfer: H and N cleared, P/V = counter non-zero.
    function automatic logic [7:0] xfer_flags(input logic [7:0] f, input logic pv);
        return {f[7:6], f[5], 1'b0, f[3], pv, 1'b0, f[0]};
    endfunction

    assign bc_dec_s = bc_r - 16'd1;
    assign pv_s     = (bc_dec_s != 16'd0);

    // State register, operand latches and the sticky bc_zero status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            op_r      <= 2'd0;
            de_r      <= 16'd0;
            hl_r      <= 16'd0;
            bc_r      <= 16'd0;
            bc_zero_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_IDLE && start) begin
                op_r <= op;
            end
            if (state_r == S_RD) begin
                de_r <= rf_out1;
                hl_r <= rf_out2;
            end
            if (state_r == S_RD_BC) begin
                bc_r <= rf_out1;
            end
            if (state_r == S_WR_C) begin
                bc_zero_r <= ~pv_s;
            end
        end
    end

    // Next-state and Moore decode of all register-file controls.
    always_comb begin
        state_nxt_s = state_r;
        busy        = 1'b1;
        done        = 1'b0;
        rf_src1     = 4'd0;
        rf_src2     = 4'd0;
        rf_dest     = 4'd0;
        rf_in       = 16'd0;
        rf_write_en = 1'b0;
        rf_f_in     = 8'd0;
        rf_f_wr     = 1'b0;
        case (state_r)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt_s = S_RD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RD: begin
                rf_src1 = REG_DE;
                rf_src2 = REG_HL;
                case (op_r)
                    OP_EX:   state_nxt_s = S_WR_A;
                    OP_LDI:  state_nxt_s = S_RD_BC;
                    OP_LDD:  state_nxt_s = S_RD_BC;
                    default: state_nxt_s = S_DONE;
                endcase
            end
            S_RD_BC: begin
                rf_src1     = REG_BC;
                state_nxt_s = S_WR_A;
            end
            S_WR_A: begin
                rf_write_en = 1'b1;
                if (op_r == OP_EX) begin
                    rf_dest = REG_DE;
                    rf_in   = hl_r;
                end else begin
                    rf_dest = REG_HL;
                    rf_in   = ptr_step(hl_r, op_r);
                end
                state_nxt_s = S_WR_B;
            end
            S_WR_B: begin
                rf_write_en = 1'b1;
                if (op_r == OP_EX) begin
                    rf_dest     = REG_HL;
                    rf_in       = de_r;
                    state_nxt_s = S_DONE;
                end else begin
                    rf_dest     = REG_DE;
                    rf_in       = ptr_step(de_r, op_r);
                    state_nxt_s = S_WR_C;
                end
            end
            S_WR_C: begin
                rf_write_en = 1'b1;
                rf_dest     = REG_BC;
                rf_in       = bc_dec_s;
                rf_f_wr     = 1'b1;
                rf_f_in     = xfer_flags(rf_reg_f, pv_s);
                state_nxt_s = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                state_nxt_s = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    assign bc_zero = bc_zero_r;

endmodule

// File: doc/reg_xfer_seq.md
# reg_xfer_seq

Multi-cycle sequencer that runs register-pair operations on the register file through its two read ports and single write port. It executes EX DE,HL and the per-iteration pointer and counter update of LDI/LDD, including the resulting flag write. It sits between the instruction decoder, which issues start/op, and the register file, whose select, write and flag ports it drives while busy.

## Interface
- No parameters. Register select width is the codebase's `reg_select`; codes are the codebase's `REG_*` constants.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- op  in  2  operation code, latched on accept: 0=EX_DE_HL, 1=LDI, 2=LDD, 3=reserved/NOP.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse in the DONE state.
- bc_zero  out  1  registered; 1 when the BC value written by the last LDI/LDD was 0000.
- rf_src1 / rf_src2  out  `reg_select`  register-file read selects.
- rf_out1 / rf_out2  in  16  register-file read data; 8-bit selects are zero-extended.
- rf_dest  out  `reg_select`  write select.
- rf_in  out  16  write data.
- rf_write_en  out  1  write strobe.
- rf_f_in  out  8  flag write data.
- rf_f_wr  out  1  flag write strobe.
- rf_reg_f  in  8  current F register.

## Operation
- States: IDLE, RD, RD_BC, WR_A, WR_B, WR_C, DONE.
- All rf_* outputs decode from the state and the latched data only (Moore). Outside the uses below, every rf_* output is 0.
- IDLE → RD on start. The op is latched on that edge.
- RD:
  - rf_src1=REG_DE, rf_src2=REG_HL.
  - At the edge, de_q←rf_out1 and hl_q←rf_out2.
  - Next state: RD_BC for op 1/2; WR_A for op 0; DONE for op 3.
- RD_BC: rf_src1=REG_BC; at the edge, bc_q←rf_out1; → WR_A.
- EX_DE_HL:
  - WR_A: dest=REG_DE, in=hl_q.
  - WR_B: dest=REG_HL, in=de_q.
  - Then DONE.
- LDI/LDD (±: + for LDI, − for LDD; all arithmetic mod 2^16):
  - WR_A: dest=REG_HL, in=hl_q±1.
  - WR_B: dest=REG_DE, in=de_q±1.
  - WR_C: dest=REG_BC, in=bc_q−1, rf_f_wr=1. rf_f_in={f[7:6], f[5], 0, f[3], pv, 0, f[0]}, where f=rf_reg_f sampled in WR_C and pv=(bc_q−1)≠0. At the edge, bc_zero←!pv. Then DONE.
- rf_write_en=1 in every WR_* state.
- DONE: done=1, busy=1; → IDLE.
- bc_zero holds its value between operations. EX and NOP do not change it.
- start while busy (including in DONE) is ignored, not queued.
- Reset in any state: state=IDLE. busy, done, bc_zero, rf_write_en, rf_f_wr all 0. Latched data cleared. Writes already committed stay committed.

## Timing
- Cycle 0 is the cycle start is sampled high in IDLE. RD occupies cycle 1.
- EX_DE_HL: writes in cycles 2–3; done in cycle 4.
- LDI/LDD: BC read in cycle 2; writes in cycles 3–5; flags written in cycle 5; done in cycle 6.
- NOP: done in cycle 2.
- A new start is accepted the cycle after DONE at the earliest. Back-to-back throughput: EX 5 cycles, LDI/LDD 7 cycles.
- RD reads are exact because write_en=0 in RD and RD_BC. The values read are those present before any write of this operation.
- Wrap cases: HL=FFFF with LDI gives 0000. DE=0000 with LDD gives FFFF. BC=0000 gives FFFF with pv=1. BC=0001 gives 0000 with pv=0, bc_zero=1.

## Test plan
- EX_DE_HL: DE=1234, HL=ABCD, start op=0 → DE=ABCD, HL=1234 after cycle 3. done only in cycle 4. rf_f_wr never 1.
- LDI: HL=1000, DE=2000, BC=0003, F=FF → HL=1001, DE=2001, BC=0002, F=EDh (H,N cleared, P/V=1), bc_zero=0, done in cycle 6.
- LDD wrap: HL=0000, DE=0000, BC=0001, F=00 → HL=FFFF, DE=FFFF, BC=0000, F=00, bc_zero=1.
- Busy rejection: start op=1 followed by start op=0 pulses in cycles 1–6 → only LDI executes. A start in cycle 7 runs EX normally.
- Reset mid-op: assert reset in WR_B of LDI → next cycle IDLE, busy=0, done=0, rf_write_en=0. No BC or flag write occurs.
- Op 3: start op=3 → no rf_write_en or rf_f_wr, done in cycle 2, bc_zero unchanged.
